// File: rtl/adsr_pkg.sv
// Shared types and helpers for the ADSR envelope block.
package adsr_pkg;

  // ADSR phase encoding, visible on the state output.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

  // Full-scale envelope level for a given envelope width.
  function automatic logic [63:0] env_max(input int unsigned envsize);
    return (64'd1 << envsize) - 64'd1;
  endfunction

endpackage

// File: rtl/adsr_sat_step.sv
// Combinational saturating envelope step: adds a step clamped to an upper
// bound, or subtracts a step clamped to a lower bound. Never wraps.
module adsr_sat_step #(
  parameter int ENVSIZE = 16
) (
  input  logic [ENVSIZE-1:0] val,
  input  logic [ENVSIZE-1:0] step,
  input  logic               sub,
  input  logic [ENVSIZE-1:0] floor_lim,
  input  logic [ENVSIZE-1:0] ceil_lim,
  output logic [ENVSIZE-1:0] res
);

  logic [ENVSIZE:0] sum;
  logic [ENVSIZE:0] diff;

  // One extra bit catches carry (add) or borrow (sub) before clamping.
  always_comb begin
    sum  = {1'b0, val} + {1'b0, step};
    diff = {1'b0, val} - {1'b0, step};
    res  = val;
    if (sub) begin
      if (diff[ENVSIZE] || (diff[ENVSIZE-1:0] < floor_lim)) res = floor_lim;
      else                                                  res = diff[ENVSIZE-1:0];
    end else begin
      if (sum > {1'b0, ceil_lim}) res = ceil_lim;
      else                        res = sum[ENVSIZE-1:0];
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: steps an envelope level once per sample_tick
// under control of a note gate and scales the oscillator sample by it.
// Latency from sample_tick to out_valid is 2 clocks.
// Optional build macro: ADSR_EXP_RELEASE_EN selects a pseudo-exponential
// release tail ((env >> EXP_SHIFT) + 1 per tick) instead of release_rate.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int BITSIZE   = 16,
  parameter int ENVSIZE   = 16,
  parameter int EXP_SHIFT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               gate,
  input  logic [ENVSIZE-1:0] attack_rate,
  input  logic [ENVSIZE-1:0] decay_rate,
  input  logic [ENVSIZE-1:0] sustain_level,
  input  logic [ENVSIZE-1:0] release_rate,
  input  logic [BITSIZE-1:0] in,
  output logic [BITSIZE-1:0] out,
  output logic               out_valid,
  output logic [ENVSIZE-1:0] env_level,
  output logic [2:0]         state,
  output logic               busy
);

  localparam logic [ENVSIZE-1:0] ENV_MAX = ENVSIZE'(env_max(ENVSIZE));
  localparam int PW = BITSIZE + ENVSIZE + 1;

  // Signed sample times unsigned level, arithmetic shift floors toward -inf.
  function automatic logic [BITSIZE-1:0] scale(input logic signed [BITSIZE-1:0] s,
                                               input logic [ENVSIZE-1:0]        e);
    logic signed [PW-1:0] prod;
    prod = PW'(s) * PW'($signed({1'b0, e}));
    prod = prod >>> ENVSIZE;
    return prod[BITSIZE-1:0];
  endfunction

  adsr_state_e               state_q, state_d, att_state;
  logic [ENVSIZE-1:0]        env_q, env_d;
  logic                      busy_q, busy_d;
  logic                      vld_p0_q, vld_p0_d;
  logic signed [BITSIZE-1:0] in_p0_q;
  logic [BITSIZE-1:0]        out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic [ENVSIZE-1:0]        att_env, dec_env, rel_env, rel_step;

`ifdef ADSR_EXP_RELEASE_EN
  assign rel_step = (env_q >> EXP_SHIFT) + ENVSIZE'(1);
  logic unused_release_rate;
  assign unused_release_rate = ^release_rate;
`else
  assign rel_step = release_rate;
  localparam int unused_exp_shift = EXP_SHIFT;
`endif

  adsr_sat_step #(.ENVSIZE(ENVSIZE)) u_att (
    .val(env_q), .step(attack_rate), .sub(1'b0),
    .floor_lim('0), .ceil_lim(ENV_MAX), .res(att_env)
  );

  adsr_sat_step #(.ENVSIZE(ENVSIZE)) u_dec (
    .val(env_q), .step(decay_rate), .sub(1'b1),
    .floor_lim(sustain_level), .ceil_lim(ENV_MAX), .res(dec_env)
  );

  adsr_sat_step #(.ENVSIZE(ENVSIZE)) u_rel (
    .val(env_q), .step(rel_step), .sub(1'b1),
    .floor_lim('0), .ceil_lim(ENV_MAX), .res(rel_env)
  );

  assign att_state = (att_env == ENV_MAX) ? DECAY : ATTACK;

  // Next-state/envelope decision on each tick; gate release beats level-reached.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (gate) begin
            env_d   = att_env;
            state_d = att_state;
          end else begin
            env_d = '0;
          end
        end
        ATTACK: begin
          if (!gate) begin
            env_d   = rel_env;
            state_d = RELEASE;
          end else begin
            env_d   = att_env;
            state_d = att_state;
          end
        end
        DECAY: begin
          if (!gate) begin
            env_d   = rel_env;
            state_d = RELEASE;
          end else begin
            env_d = dec_env;
            if (dec_env == sustain_level) state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!gate) begin
            env_d   = rel_env;
            state_d = RELEASE;
          end else begin
            env_d = sustain_level;
          end
        end
        RELEASE: begin
          if (gate) begin
            env_d   = att_env;
            state_d = att_state;
          end else begin
            env_d = rel_env;
            if (rel_env == '0) state_d = IDLE;
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);

    // Stage p0 -> output: scale the captured sample by the registered level.
    vld_p0_d    = sample_tick;
    out_valid_d = vld_p0_q;
    out_d       = vld_p0_q ? scale(in_p0_q, env_q) : out_q;
  end

  // Control state, envelope and output registers; reset aborts at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      env_q       <= '0;
      busy_q      <= 1'b0;
      vld_p0_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      busy_q      <= busy_d;
      vld_p0_q    <= vld_p0_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Stage p0: capture the oscillator sample alongside the envelope step.
  always_ff @(posedge clk) begin
    if (sample_tick) in_p0_q <= $signed(in);
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign env_level = env_q;
  assign state     = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Testbench for adsr_envelope: behavioural envelope model plus directed ticks.
module tb_adsr_envelope;

  localparam int EMAX      = 65535;
  localparam int EXP_SHIFT = 8;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic               gate;
  logic [15:0]        attack_rate, decay_rate, sustain_level, release_rate;
  logic signed [15:0] in_s;
  logic signed [15:0] out_s;
  logic               out_valid;
  logic [15:0]        env_level;
  logic [2:0]         state;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  adsr_envelope #(.BITSIZE(16), .ENVSIZE(16), .EXP_SHIFT(EXP_SHIFT)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .in(in_s), .out(out_s), .out_valid(out_valid),
    .env_level(env_level), .state(state), .busy(busy)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_env, m_st, m_out, pend_out;
  bit m_val, pend;

  function automatic int floor_scale(input int s, input int e);
    longint p, q;
    p = longint'(s) * longint'(e);
    q = p / 65536;
    if (p < 0 && q * 65536 != p) q = q - 1;
    return int'(q);
  endfunction

  function automatic int rel_step(input int e);
`ifdef ADSR_EXP_RELEASE_EN
    return (e >> EXP_SHIFT) + 1;
`else
    return int'(release_rate);
`endif
  endfunction

  task automatic model_tick();
    int att, dec, rel;
    att = m_env + int'(attack_rate);
    if (att > EMAX) att = EMAX;
    dec = m_env - int'(decay_rate);
    if (dec < int'(sustain_level)) dec = int'(sustain_level);
    rel = m_env - rel_step(m_env);
    if (rel < 0) rel = 0;
    if (gate) begin
      if (m_st == S_IDLE || m_st == S_ATTACK || m_st == S_RELEASE) begin
        m_env = att;
        m_st  = (att == EMAX) ? S_DECAY : S_ATTACK;
      end else if (m_st == S_DECAY) begin
        m_env = dec;
        if (dec == int'(sustain_level)) m_st = S_SUSTAIN;
      end else begin
        m_env = int'(sustain_level);
      end
    end else if (m_st == S_IDLE) begin
      m_env = 0;
    end else begin
      if (m_st == S_RELEASE && rel == 0) m_st = S_IDLE;
      else                               m_st = S_RELEASE;
      m_env = rel;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_env = 0; m_st = S_IDLE; m_out = 0; m_val = 1'b0; pend = 1'b0;
    end else begin
      m_val = pend;
      if (pend) m_out = pend_out;
      pend = 1'b0;
      if (sample_tick) begin
        model_tick();
        pend_out = floor_scale(int'(in_s), m_env);
        pend     = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_state", state, m_st);
      chk("cyc_env", env_level, m_env);
      chk("cyc_busy", busy, (m_st != S_IDLE));
      chk("cyc_out_valid", out_valid, m_val);
      chk("cyc_out", out_s, m_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_tick(input bit g);
    @(negedge clk); gate = g; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_to_idle(input int max_ticks);
    int k;
    k = 0;
    while (state != 3'(S_IDLE) && k < max_ticks) begin
      do_tick(1'b0);
      k++;
    end
    chk("rel_idle_state", state, S_IDLE);
    chk("rel_idle_env", env_level, 0);
    chk("rel_idle_busy", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int att_exp[4];
    int dec_exp[4];
    int rel_exp[4];
    int rel_st[4];
    int mid_exp, post_exp;
    att_exp = '{16384, 32768, 49152, 65535};
    dec_exp = '{57343, 49151, 40959, 32768};
    rel_exp = '{22768, 12768, 2768, 0};
    rel_st  = '{S_RELEASE, S_RELEASE, S_RELEASE, S_IDLE};
`ifdef ADSR_EXP_RELEASE_EN
    mid_exp = 32511; post_exp = 48895;
`else
    mid_exp = 12768; post_exp = 29152;
`endif

    reset = 1'b1; sample_tick = 1'b0; gate = 1'b0; in_s = 16'sd16384;
    attack_rate = 16'd16384; decay_rate = 16'd8192;
    sustain_level = 16'd32768; release_rate = 16'd10000;
    repeat (3) @(negedge clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_env", env_level, 0);
    chk("rst_out", out_s, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Attack up to full scale, then decay to sustain.
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b1);
      chk("attack_env", env_level, att_exp[i]);
    end
    chk("attack_to_decay", state, S_DECAY);
    chk("out_env_max", out_s, 16383);
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b1);
      chk("decay_env", env_level, dec_exp[i]);
    end
    chk("decay_to_sustain", state, S_SUSTAIN);
    chk("out_env_half", out_s, 8192);

    // Release all the way down.
`ifdef ADSR_EXP_RELEASE_EN
    release_to_idle(3000);
`else
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b0);
      chk("release_env", env_level, rel_exp[i]);
      chk("release_state", state, rel_st[i]);
    end
    chk("release_busy", busy, 0);
`endif

    // Back to sustain, partial release, then retrigger from the current level.
    for (int i = 0; i < 8; i++) do_tick(1'b1);
    chk("resustain_env", env_level, 32768);
    do_tick(1'b0);
    do_tick(1'b0);
    chk("retrig_pre_env", env_level, mid_exp);
    do_tick(1'b1);
    chk("retrig_state", state, S_ATTACK);
    chk("retrig_env", env_level, post_exp);
    release_to_idle(3000);

    // sustain at full scale: decay ends on the first tick; negative sample floors.
    sustain_level = 16'd65535;
    for (int i = 0; i < 4; i++) do_tick(1'b1);
    in_s = -16'sd16384;
    do_tick(1'b1);
    chk("full_sustain_state", state, S_SUSTAIN);
    chk("full_sustain_env", env_level, 65535);
    chk("out_neg_floor", out_s, -16384);

    // Live sustain change to zero: silent but still busy.
    sustain_level = 16'd0; in_s = 16'sd16384;
    do_tick(1'b1);
    chk("silent_env", env_level, 0);
    chk("silent_out", out_s, 0);
    chk("silent_busy", busy, 1);

    // Mixed sample values at a non-power-of-two level.
    sustain_level = 16'd40000;
    in_s = -16'sd1;     do_tick(1'b1); chk("out_minus_one", out_s, -1);
    in_s = -16'sd32768; do_tick(1'b1); chk("out_most_neg", out_s, -20000);
    in_s = 16'sd32767;  do_tick(1'b1);
    in_s = 16'sd12345;  do_tick(1'b1);
    release_to_idle(3000);

    // Zero attack rate holds the envelope in ATTACK; no ticks means no change.
    attack_rate = 16'd0;
    for (int i = 0; i < 3; i++) do_tick(1'b1);
    chk("hold_state", state, S_ATTACK);
    chk("hold_env", env_level, 0);
    gate = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_tick_hold", state, S_ATTACK);

    // Asynchronous reset right after a tick: abort with no pending output pulse.
    attack_rate = 16'd16384; in_s = 16'sd16384;
    do_tick(1'b1);
    @(negedge clk); gate = 1'b1; sample_tick = 1'b1;
    @(posedge clk); #2; reset = 1'b1;
    #1;
    chk("async_rst_state", state, S_IDLE);
    chk("async_rst_env", env_level, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out", out_s, 0);
    chk("async_rst_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_tick_valid", out_valid, 0);
    chk("rst_tick_env", env_level, 0);
    sample_tick = 1'b0; reset = 1'b0; gate = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_state", state, S_IDLE);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
